// File: rtl/sseg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl_if
// Purpose : value-update handshake between a number producer (score/counter
//           logic) and the seven-segment scan controller.
// Signals :
//   num_in    [13:0]  requested display value, binary (producer -> controller)
//   num_valid         num_in is valid                  (producer -> controller)
//   num_ready         controller can accept a value    (controller -> producer)
// Modports: master = producer side, slave = controller side.
// -----------------------------------------------------------------------------
interface sseg_scan_ctrl_if;
  logic [13:0] num_in;
  logic        num_valid;
  logic        num_ready;

  modport master (output num_in, output num_valid, input num_ready);
  modport slave  (input num_in, input num_valid, output num_ready);
endinterface

// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
// Purpose : scan sequencer for a 4-digit seven-segment decoder. Steps the digit
//           select on a fixed refresh schedule and presents the displayed
//           number. New values arrive over a valid/ready handshake and are
//           committed only at frame boundaries, so one scan never mixes digits
//           of two different values.
// Parameters:
//   CLK_HZ    input clock frequency in Hz
//   DIGIT_HZ  per-digit refresh rate in Hz; DIV = CLK_HZ/DIGIT_HZ >= 2
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          scan enable; low freezes the tick counter and dig_sel
//   num_bus     slave side of the value handshake (num_in/num_valid/num_ready)
//   num         committed value to the decoder, 0..9999
//   dig_sel     digit currently scanned
//   frame_done  one-cycle pulse after the end of each 4-digit frame
//   sat         committed value was clamped to 9999
//   dig_blank   current digit is a blanked leading zero
// Optional feature:
//   SSEG_SCAN_BLANK_EN  when defined, leading-zero blanking drives dig_blank;
//                       otherwise dig_blank is tied low.
// -----------------------------------------------------------------------------
module sseg_scan_ctrl #(
  parameter int CLK_HZ   = 50000000,
  parameter int DIGIT_HZ = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  sseg_scan_ctrl_if.slave         num_bus,
  output logic [13:0]             num,
  output logic [1:0]              dig_sel,
  output logic                    frame_done,
  output logic                    sat,
  output logic                    dig_blank
);

  localparam int DIV = CLK_HZ / DIGIT_HZ;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("sseg_scan_ctrl: CLK_HZ/DIGIT_HZ must be at least 2");
    end
  endgenerate

  typedef enum logic {IDLE, PEND} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    dig_sel_q, dig_sel_d;
  logic [13:0]   num_q, num_d;
  logic [13:0]   pending_q, pending_d;
  logic          pending_sat_q, pending_sat_d;
  logic          sat_q, sat_d;
  logic          num_ready_q, num_ready_d;
  logic          frame_done_q, frame_done_d;
  logic          tick_last;
  logic          frame_end;

  // Refresh timebase: tick walks 0..DIV-1, each wrap advances the digit.
  always_comb begin
    tick_d    = tick_q;
    dig_sel_d = dig_sel_q;
    tick_last = (tick_q == TW'(DIV - 1));
    if (en) begin
      if (tick_last) begin
        tick_d    = '0;
        dig_sel_d = dig_sel_q + 2'd1;
      end else begin
        tick_d    = tick_q + TW'(1);
      end
    end
  end

  assign frame_end    = en && tick_last && (dig_sel_q == 2'd3);
  assign frame_done_d = frame_end;

  // Handshake FSM. A value captured on a frame-end cycle moves to PEND on that
  // edge, so it can only be committed by the following frame end.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    pending_sat_d = pending_sat_q;
    num_d         = num_q;
    sat_d         = sat_q;
    case (state_q)
      IDLE: begin
        if (num_bus.num_valid) begin
          if (num_bus.num_in > 14'd9999) begin
            pending_d     = 14'd9999;
            pending_sat_d = 1'b1;
          end else begin
            pending_d     = num_bus.num_in;
            pending_sat_d = 1'b0;
          end
          state_d = PEND;
        end
      end
      PEND: begin
        if (frame_end) begin
          num_d   = pending_q;
          sat_d   = pending_sat_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered decode of the next state keeps num_valid off the ready path.
    num_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      dig_sel_q     <= 2'd0;
      num_q         <= 14'd0;
      pending_q     <= 14'd0;
      pending_sat_q <= 1'b0;
      sat_q         <= 1'b0;
      num_ready_q   <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      dig_sel_q     <= dig_sel_d;
      num_q         <= num_d;
      pending_q     <= pending_d;
      pending_sat_q <= pending_sat_d;
      sat_q         <= sat_d;
      num_ready_q   <= num_ready_d;
      frame_done_q  <= frame_done_d;
    end
  end

`ifdef SSEG_SCAN_BLANK_EN
  logic dig_blank_q, dig_blank_d;

  // Evaluated on next-cycle values so the flag lines up with dig_sel and num.
  // Since num never exceeds 9999, "all digits at or above position k are zero"
  // reduces to num < 10**k.
  always_comb begin
    dig_blank_d = 1'b0;
    case (dig_sel_d)
      2'd1:    dig_blank_d = (num_d < 14'd10);
      2'd2:    dig_blank_d = (num_d < 14'd100);
      2'd3:    dig_blank_d = (num_d < 14'd1000);
      default: dig_blank_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_blank_q <= 1'b0;
    end else begin
      dig_blank_q <= dig_blank_d;
    end
  end

  assign dig_blank = dig_blank_q;
`else
  assign dig_blank = 1'b0;
`endif

  assign num               = num_q;
  assign dig_sel           = dig_sel_q;
  assign sat               = sat_q;
  assign frame_done        = frame_done_q;
  assign num_bus.num_ready = num_ready_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
// Purpose : directed bench for sseg_scan_ctrl with DIV = 4 (frame = 16 cycles).
//           Expected per-frame values are queued by the stimulus process and
//           popped by a monitor on every frame_done pulse.
// -----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

  localparam int CLK_HZ   = 16;
  localparam int DIGIT_HZ = 4;

`ifdef SSEG_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [13:0] num;
  logic [1:0]  dig_sel;
  logic        frame_done;
  logic        sat;
  logic        dig_blank;

  sseg_scan_ctrl_if bus ();

  sseg_scan_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .DIGIT_HZ (DIGIT_HZ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .num_bus    (bus),
    .num        (num),
    .dig_sel    (dig_sel),
    .frame_done (frame_done),
    .sat        (sat),
    .dig_blank  (dig_blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] num;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc;
  int   en_cnt;

  // Cycle counter since reset release, and count of enabled edges which
  // defines where the scan position should be.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= 0;
      en_cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (en) en_cnt <= en_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [13:0] value);
    bus.num_valid = valid;
    bus.num_in    = value;
  endtask

  task automatic push_exp(input int n, input bit s);
    exp_t e;
    e.num = 14'(n);
    e.sat = s;
    exp_q.push_back(e);
  endtask

  // Advance to a given cycle index, checking the scan position on every edge.
  task automatic step_to(input int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
      checkOutput("dig_sel", 32'(dig_sel), 32'((en_cnt / 4) % 4));
    end
    if (cyc != target) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL step_to: reached cycle %0d, expected %0d", cyc, target);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_num"}, 32'(num), 32'd0);
    checkOutput({tag, "_dig_sel"}, 32'(dig_sel), 32'd0);
    checkOutput({tag, "_num_ready"}, 32'(bus.num_ready), 32'd1);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_sat"}, 32'(sat), 32'd0);
    checkOutput({tag, "_dig_blank"}, 32'(dig_blank), 32'd0);
  endtask

  // Scoreboard monitor: every frame_done pulse must match the next queued
  // expectation, and the scan must be back at digit 0.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL frame_unexpected at cycle %0d: got frame_done=1, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("frame_num", 32'(num), 32'(e.num));
        checkOutput("frame_sat", 32'(sat), 32'(e.sat));
        checkOutput("frame_dig_sel", 32'(dig_sel), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    applyStimulus(1'b0, 14'd0);
    #20;
    check_reset_values("reset");
    #2;
    rst_n = 1'b1;

    // Basic capture and commit at the first frame end.
    step_to(5);
    applyStimulus(1'b1, 14'd1234);
    push_exp(1234, 1'b0);
    step_to(6);
    applyStimulus(1'b0, 14'd0);
    checkOutput("ready_fall", 32'(bus.num_ready), 32'd0);
    step_to(15);
    checkOutput("num_before_commit", 32'(num), 32'd0);
    checkOutput("frame_done_early", 32'(frame_done), 32'd0);
    step_to(16);
    checkOutput("num_commit_1234", 32'(num), 32'd1234);
    checkOutput("ready_return", 32'(bus.num_ready), 32'd1);
    checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
    step_to(17);
    checkOutput("frame_done_one_cycle", 32'(frame_done), 32'd0);

    // Saturation, then a small value clears sat.
    applyStimulus(1'b1, 14'd12000);
    push_exp(9999, 1'b1);
    step_to(18);
    applyStimulus(1'b0, 14'd0);
    step_to(32);
    checkOutput("sat_num", 32'(num), 32'd9999);
    checkOutput("sat_flag", 32'(sat), 32'd1);
    applyStimulus(1'b1, 14'd7);
    push_exp(7, 1'b0);
    step_to(33);
    applyStimulus(1'b0, 14'd0);
    step_to(48);
    checkOutput("num_7", 32'(num), 32'd7);
    checkOutput("sat_clear", 32'(sat), 32'd0);

    // Capture on a frame-end cycle waits for the following frame end;
    // a value offered while not ready is ignored.
    push_exp(7, 1'b0);
    push_exp(321, 1'b0);
    step_to(63);
    applyStimulus(1'b1, 14'd321);
    step_to(64);
    applyStimulus(1'b0, 14'd0);
    checkOutput("no_same_cycle_commit", 32'(num), 32'd7);
    checkOutput("ready_after_edge_capture", 32'(bus.num_ready), 32'd0);
    step_to(66);
    applyStimulus(1'b1, 14'd555);
    step_to(70);
    applyStimulus(1'b0, 14'd0);
    step_to(80);
    checkOutput("num_321", 32'(num), 32'd321);

    // Scan frozen while a value is pending.
    step_to(81);
    applyStimulus(1'b1, 14'd42);
    push_exp(42, 1'b0);
    step_to(82);
    applyStimulus(1'b0, 14'd0);
    step_to(85);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_to(cyc + 1);
      checkOutput("frozen_frame_done", 32'(frame_done), 32'd0);
      checkOutput("frozen_num", 32'(num), 32'd321);
    end
    en = 1'b1;
    step_to(115);
    checkOutput("num_hold_after_freeze", 32'(num), 32'd321);
    step_to(116);
    checkOutput("num_42", 32'(num), 32'd42);

    // Leading-zero blanking across one full frame of num=42.
    push_exp(42, 1'b0);
    for (int c = 116; c < 132; c++) begin
      step_to(c);
      checkOutput("dig_blank", 32'(dig_blank),
                  32'(BLANK_ON && (((en_cnt / 4) % 4) >= 2)));
    end
    step_to(132);

    // Reset while pending discards the value.
    step_to(133);
    applyStimulus(1'b1, 14'd999);
    step_to(134);
    applyStimulus(1'b0, 14'd0);
    checkOutput("ready_pend_999", 32'(bus.num_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    #10;
    rst_n = 1'b1;
    push_exp(0, 1'b0);
    step_to(16);
    checkOutput("pending_lost", 32'(num), 32'd0);
    checkOutput("ready_after_reset", 32'(bus.num_ready), 32'd1);
    step_to(17);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Sequencer for the 4-digit seven-segment decoder: drives its digit select on a fixed refresh schedule and feeds it the displayed number.
- Accepts new display values over a valid/ready handshake and commits them only at frame boundaries, so a single scan never shows digits of two different values.
- Sits between application logic (score/counter producers) and the combinational decoder.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- DIGIT_HZ, 1000, per-digit refresh rate in Hz. DIV = CLK_HZ/DIGIT_HZ clocks per digit; DIV must be >= 2, enforced by an elaboration-time check.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; low freezes tick counter and dig_sel.
- num_in  in  14  requested display value, binary.
- num_valid  in  1  num_in valid.
- num_ready  out  1  controller can accept a value.
- num  out  14  committed value to decoder, 0..9999.
- dig_sel  out  2  digit currently scanned, to decoder.
- frame_done  out  1  one-cycle pulse at end of each 4-digit frame.
- sat  out  1  committed value was clamped.
- dig_blank  out  1  current digit is a blanked leading zero (see Optional Feature).

Behaviour:
- Reset (async, rst_n low): num=0, dig_sel=0, tick=0, state=IDLE, num_ready=1, frame_done=0, sat=0, dig_blank=0, pending registers=0.
- Tick counter width is clog2(DIV). When en=1 it counts 0..DIV-1.
  - At DIV-1 it wraps to 0 and dig_sel increments mod 4 (3 -> 0).
  - When en=0, tick and dig_sel hold.
- Frame end: en=1, tick=DIV-1 and dig_sel=3. frame_done is registered and is high for the cycle after frame end (one cycle only).
- FSM states:
  - IDLE: num_ready=1. num_valid=1 captures num_in into pending -> PEND.
  - PEND: num_ready=0. At frame end, num<=pending, sat<=pending_sat -> IDLE.
- Capture clamps: if num_in > 9999, pending=9999 and pending_sat=1; otherwise pending=num_in and pending_sat=0.
- Capture in IDLE on the same cycle as a frame end: the value is captured, but the commit waits for the following frame end. No same-cycle commit.
- num_valid while in PEND is ignored. The producer holds num_valid until it sees num_ready. num_ready is a registered state decode, with no combinational path from num_valid.
- Commit latency: at most one frame (4*DIV cycles) plus 1 cycle after the capture cycle.
- en=0 in PEND: no frame end occurs, so the commit is deferred indefinitely; num and sat hold.
- num, sat and dig_sel are registered. The decoder output follows combinationally.
- Reset mid-PEND discards the pending value.

Optional Feature:
- Macro SSEG_SCAN_BLANK_EN, leading-zero blanking.
- Defined: dig_blank is registered and updates whenever dig_sel or num changes. It is 1 when dig_sel>0 and every digit of num at position >= dig_sel is zero. Examples: num=42 blanks digits 2 and 3; num=0 blanks digits 1..3 and digit 0 is always shown. Downstream gates the anode with dig_blank.
- Not defined: dig_blank is tied 0 and the blanking logic is absent.

Test Plan (CLK_HZ=16, DIGIT_HZ=4 -> DIV=4, frame = 16 cycles):
- Release reset, en=1: dig_sel steps 0,1,2,3,0 every 4 cycles. frame_done pulses every 16 cycles, first one at cycle 16 after reset release. num=0.
- At cycle 5 drive num_in=1234 with num_valid=1 for 1 cycle: num_ready falls next cycle. num stays 0 until the frame end at cycle 15, num=1234 from cycle 16, num_ready=1 again.
- num_in=12000 valid in IDLE: after the next frame end, num=9999 and sat=1. Then num_in=7 commits: sat=0, num=7.
- Valid asserted exactly on a frame-end cycle: commit occurs at the next frame end, 16 cycles later, not the current one. A second value offered while num_ready=0 is not captured.
- en=0 for 20 cycles while in PEND: dig_sel and tick frozen, no frame_done, num unchanged. With en=1 the commit resumes at the next frame end. Assert rst_n mid-PEND: all outputs return to reset values asynchronously and the pending value is lost.
- With SSEG_SCAN_BLANK_EN defined and num=42: dig_blank=0 for dig_sel 0,1 and 1 for dig_sel 2,3. Without the macro, dig_blank=0 throughout.
